// File: rtl/gnrc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gnrc_pkg
// Description : Shared types for the generic round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package gnrc_pkg;

  // Arbiter control state: IDLE has no grant, GRANT presents one.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage : gnrc_pkg
`default_nettype wire

// File: rtl/gnrc_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : gnrc_rr_pick
// Description : Combinational wrap-around priority scan. Returns the first set
//               request starting at ptr and wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module gnrc_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan from the farthest offset down to offset 0 so the nearest hit wins.
  always_comb begin
    logic [W:0]   sum;
    logic [W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      // One extra bit keeps ptr+i (at most 2N-2) from overflowing before wrap.
      sum = {1'b0, ptr} + (W+1)'(i);
      if (sum >= (W+1)'(N)) begin
        sum = sum - (W+1)'(N);
      end
      cand = sum[W-1:0];
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : gnrc_rr_pick
`default_nettype wire

// File: rtl/gnrc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gnrc_rr_arbiter
// Description : Round-robin arbiter with registered valid/ready grant output
//               and a binary grant index. One grant per cycle back-to-back.
//               Optional macro GNRC_RR_ARBITER_LOCK_EN adds lock_i, which
//               re-grants the current winner while it keeps requesting.
// Revision    : 1.0 - initial release
// ============================================================================
module gnrc_rr_arbiter
  import gnrc_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
`ifdef GNRC_RR_ARBITER_LOCK_EN
  input  logic         lock_i,
`endif
  output logic         gnt_valid_o,
  input  logic         gnt_ready_i,
  output logic [W-1:0] gnt_idx_o
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  state_e       state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;

  logic [W-1:0] next_ptr;
  logic [W-1:0] pick_ptr;
  logic         pick_found;
  logic [W-1:0] pick_idx;
  logic         handshake;
  logic         lock_hold;

  // Pointer that a handshake would install: one past the current winner, mod N.
  assign next_ptr  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  // In GRANT the scan must already use the post-handshake pointer.
  assign pick_ptr  = (state_q == GRANT) ? next_ptr : ptr_q;
  assign handshake = valid_q & gnt_ready_i;

`ifdef GNRC_RR_ARBITER_LOCK_EN
  assign lock_hold = lock_i & req_i[idx_q];
`else
  assign lock_hold = 1'b0;
`endif

  gnrc_rr_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .req   (req_i),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state logic: grant on request, hold until handshake, then re-pick.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          idx_d   = pick_idx;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (handshake && !lock_hold) begin
          ptr_d = next_ptr;
          if (pick_found) begin
            idx_d = pick_idx;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous clear of any outstanding grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign gnt_valid_o = valid_q;
  assign gnt_idx_o   = idx_q;

endmodule : gnrc_rr_arbiter
`default_nettype wire

// File: tb/tb_gnrc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gnrc_rr_arbiter
// Description : Scoreboard bench for gnrc_rr_arbiter (N=4 and N=5 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gnrc_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req4 = '0;
  logic       rdy4 = 1'b0;
  logic       lock4 = 1'b0;
  logic       vld4;
  logic [1:0] idx4;
  logic [4:0] req5 = '0;
  logic       rdy5 = 1'b0;
  logic       lock5 = 1'b0;
  logic       vld5;
  logic [2:0] idx5;

  int checks = 0;
  int failures = 0;
  int q4[$];
  int q5[$];

  always #5 clk = ~clk;

  gnrc_rr_arbiter #(.N(4)) u_dut4 (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req4),
`ifdef GNRC_RR_ARBITER_LOCK_EN
    .lock_i      (lock4),
`endif
    .gnt_valid_o (vld4),
    .gnt_ready_i (rdy4),
    .gnt_idx_o   (idx4)
  );

  gnrc_rr_arbiter #(.N(5)) u_dut5 (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req5),
`ifdef GNRC_RR_ARBITER_LOCK_EN
    .lock_i      (lock5),
`endif
    .gnt_valid_o (vld5),
    .gnt_ready_i (rdy5),
    .gnt_idx_o   (idx5)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake seen mid-cycle pops and compares one expected index.
  always @(negedge clk) begin
    if (!rst && vld4 && rdy4) begin
      if (q4.size() == 0) check("n4_unexpected_hs", int'(idx4), -1);
      else check("n4_hs_idx", int'(idx4), q4.pop_front());
    end
    if (!rst && vld5 && rdy5) begin
      if (q5.size() == 0) check("n5_unexpected_hs", int'(idx5), -1);
      else check("n5_hs_idx", int'(idx5), q5.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
  endtask

  initial begin
    // Reset held with all requests: no grant, index zero.
    req4 = 4'b1111;
    rdy4 = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("rst_valid", int'(vld4), 0);
      check("rst_idx", int'(idx4), 0);
      step();
    end
    q4.push_back(0); q4.push_back(1); q4.push_back(2);
    q4.push_back(3); q4.push_back(0); q4.push_back(1);
    rst = 1'b0;
    step();
    check("first_valid", int'(vld4), 1);
    check("first_idx", int'(idx4), 0);
    repeat (5) step();
    req4 = 4'b0000;
    step();
    check("t1_drop", int'(vld4), 0);

    // Alternating requesters 1 and 3, then withdraw.
    apply_reset();
    req4 = 4'b1010;
    q4.push_back(1); q4.push_back(3); q4.push_back(1); q4.push_back(3);
    rst = 1'b0;
    repeat (4) step();
    req4 = 4'b0000;
    step();
    check("t2_drop", int'(vld4), 0);

    // Stall on index 2 while requests change, then wrap from ptr 3 to 0.
    apply_reset();
    req4 = 4'b0100;
    rdy4 = 1'b0;
    q4.push_back(2); q4.push_back(0);
    rst = 1'b0;
    step();
    req4 = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", int'(vld4), 1);
      check("stall_idx", int'(idx4), 2);
      step();
    end
    rdy4 = 1'b1;
    step();
    check("wrap_idx", int'(idx4), 0);
    req4 = 4'b0000;
    step();
    check("t3_drop", int'(vld4), 0);

    // Asynchronous reset mid-cycle discards a pending grant.
    apply_reset();
    req4 = 4'b1111;
    rdy4 = 1'b0;
    rst = 1'b0;
    step();
    #2;
    check("pre_async_valid", int'(vld4), 1);
    rst = 1'b1;
    #1;
    check("async_valid", int'(vld4), 0);
    check("async_idx", int'(idx4), 0);
    req4 = 4'b0000;
    step();

    // N=5 wrap: 4 -> 0.
    req5 = 5'b10001;
    rdy5 = 1'b1;
    q5.push_back(0); q5.push_back(4); q5.push_back(0); q5.push_back(4);
    rst = 1'b0;
    repeat (4) step();
    req5 = 5'b00000;
    step();
    check("n5_drop", int'(vld5), 0);
    rdy5 = 1'b0;

`ifdef GNRC_RR_ARBITER_LOCK_EN
    // Lock keeps re-granting requester 1; unlocking moves on to 2.
    apply_reset();
    req4 = 4'b0110;
    lock4 = 1'b1;
    rdy4 = 1'b1;
    q4.push_back(1); q4.push_back(1); q4.push_back(1); q4.push_back(2);
    rst = 1'b0;
    repeat (3) step();
    lock4 = 1'b0;
    step();
    check("unlock_idx", int'(idx4), 2);
    req4 = 4'b0000;
    step();
    check("lock_drop", int'(vld4), 0);
`endif

    step();
    check("n4_queue_left", q4.size(), 0);
    check("n5_queue_left", q5.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gnrc_rr_arbiter
`default_nettype wire

// File: doc/gnrc_rr_arbiter.md
GNRC_RR_ARBITER -- requirements
Module: gnrc_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, range >=2.
REQ-002 SHALL have parameter W, default $clog2(N): grant index width, auto-derived and never overridden.
REQ-003 SHALL have port clk_i, input, 1: clock, all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port req_i, input, N: request vector, bit i = requester i.
REQ-006 SHALL have port gnt_valid_o, output, 1: grant valid, registered.
REQ-007 SHALL have port gnt_ready_i, input, 1: downstream accepts the grant.
REQ-008 SHALL have port gnt_idx_o, output, W: binary index of the granted requester, registered.

Function
REQ-009 SHALL implement states IDLE (no grant) and GRANT (grant presented), held in one registered state variable.
REQ-010 SHALL keep a priority pointer ptr (W bits): the requester index with highest priority.
REQ-011 SHALL pick the first set req_i bit scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
REQ-012 SHALL compute every pointer increment modulo N, including non-power-of-2 N (e.g. N=5: 4 -> 0).
REQ-013 In IDLE with req_i != 0, SHALL go to GRANT, load gnt_idx_o with the pick and assert gnt_valid_o on the next edge (latency 1 cycle).
REQ-014 In IDLE with req_i == 0, SHALL stay IDLE with gnt_valid_o=0.
REQ-015 A handshake SHALL be a cycle with gnt_valid_o=1 and gnt_ready_i=1.
REQ-016 In GRANT without handshake, gnt_idx_o and gnt_valid_o SHALL stay stable, regardless of req_i changes, including withdrawal.
REQ-017 On handshake, ptr SHALL become (gnt_idx_o+1) mod N, and a fresh pick SHALL use that new pointer with the current req_i.
REQ-018 On handshake with a non-empty fresh pick, the arbiter SHALL stay in GRANT and load the new index (back-to-back, one grant per cycle).
REQ-019 On handshake with req_i == 0, the arbiter SHALL go to IDLE and drop gnt_valid_o.
REQ-020 gnt_ready_i in IDLE SHALL be ignored.

Reset
REQ-021 rst_i=1 SHALL force state=IDLE, ptr=0, gnt_valid_o=0, gnt_idx_o=0 immediately, without waiting for clk_i.
REQ-022 Reset asserted during GRANT SHALL discard the outstanding grant.
REQ-023 After reset release, the first pick SHALL use ptr=0.

Configuration
REQ-024 Macro GNRC_RR_ARBITER_LOCK_EN defined SHALL add input port lock_i, 1 bit.
REQ-025 With the macro, a handshake with lock_i=1 and req_i[gnt_idx_o]=1 SHALL re-grant the same index, stay in GRANT and leave ptr unchanged.
REQ-026 With the macro, lock_i=1 while req_i[gnt_idx_o]=0 SHALL behave as REQ-017/018/019.
REQ-027 Without the macro, lock_i SHALL not exist and behaviour SHALL be exactly REQ-009..020.

Structure
REQ-028 Package gnrc_pkg SHALL hold the state enum typedef (IDLE, GRANT).
REQ-029 A combinational sub-module gnrc_rr_pick (params N, W; inputs req, ptr; outputs found, idx) SHALL implement the wrap-around scan and be used for both IDLE and handshake picks.
REQ-030 gnt_idx_o SHALL be directly consumable by a binary-to-one-hot decoder, with no extra encoding.

Verification (N=4 unless stated)
REQ-031 Reset held, req_i=4'b1111 -> gnt_valid_o=0 and gnt_idx_o=0 throughout; after release, valid rises one cycle later with idx=0.
REQ-032 req_i=4'b1111, gnt_ready_i=1 constant -> idx sequence 0,1,2,3,0,1, one per cycle, valid continuously 1.
REQ-033 req_i=4'b1010, ready=1 -> idx 1,3,1,3; then req_i=0 -> valid drops the cycle after the last handshake.
REQ-034 Grant idx=2, ready=0 for 5 cycles while req_i changes to 4'b0001 -> idx stays 2, valid stays 1; ready=1 -> next idx=0 (ptr 3 wraps).
REQ-035 rst_i pulsed mid-cycle while valid=1 -> valid falls before the next clk_i edge; N=5 with req=5'b10001 and ready=1 -> idx 0,4,0,4.
REQ-036 With GNRC_RR_ARBITER_LOCK_EN, req_i=4'b0110, lock_i=1, ready=1 -> idx 1,1,1; lock_i=0 -> idx 2.
